// File: rtl/iir_pkg.sv
// Shared definitions for the serial-to-parallel input demultiplexer and the
// output-side multiplexer: default widths, the demux FSM states, sample widening.
package iir_pkg;

   localparam int unsigned DEF_NUM_CH = 3;
   localparam int unsigned DEF_IN_W   = 11;
   localparam int unsigned DEF_OUT_W  = 36;
   localparam int unsigned DEF_FRAC   = 24;
   localparam int unsigned ERR_CNT_W  = 8;

   typedef enum logic {
      ST_HUNT    = 1'b0,
      ST_COLLECT = 1'b1
   } demux_state_t;

   // Sign-extend a serial sample and place its LSB at the fraction point.
   function automatic logic signed [DEF_OUT_W-1:0] widen(input logic signed [DEF_IN_W-1:0] x);
      return DEF_OUT_W'(x) <<< DEF_FRAC;
   endfunction

endpackage

// File: rtl/in_demux.sv
// Time-multiplexed serial sample stream to per-channel parallel lanes.
// Optional build macro IN_DEMUX_ERRCNT_EN enables the saturating framing-error counter.
module in_demux
   import iir_pkg::*;
#(
   parameter int unsigned NUM_CH = DEF_NUM_CH,
   parameter int unsigned IN_W   = DEF_IN_W,
   parameter int unsigned OUT_W  = DEF_OUT_W,
   parameter int unsigned FRAC   = DEF_FRAC
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic                    in_sof,
   input  logic signed [IN_W-1:0]  in_data,
   output logic signed [OUT_W-1:0] out_data [0:NUM_CH-1],
   output logic                    out_valid,
   output logic                    sync_err,
   output logic [ERR_CNT_W-1:0]    err_cnt
);

   localparam int unsigned CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

   demux_state_t            state;
   logic [CNT_W-1:0]        ch_cnt;
   logic signed [OUT_W-1:0] shadow [0:NUM_CH-1];
   logic signed [OUT_W-1:0] wide_c;

   // Default geometry uses the shared widening function; other widths use the same rule inline.
   generate
      if (IN_W == DEF_IN_W && OUT_W == DEF_OUT_W && FRAC == DEF_FRAC) begin : g_widen_pkg
         assign wide_c = widen(in_data);
      end else begin : g_widen_gen
         assign wide_c = OUT_W'(in_data) <<< FRAC;
      end
   endgenerate

   // Framing FSM, shadow capture and atomic frame publish.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_HUNT;
         ch_cnt    <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            shadow[i]   <= '0;
            out_data[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         if (in_valid) begin
            case (state)
               ST_HUNT: begin
                  if (in_sof) begin
                     shadow[0] <= wide_c;
                     ch_cnt    <= CNT_W'(1);
                     state     <= ST_COLLECT;
                  end
               end
               ST_COLLECT: begin
                  if (ch_cnt == '0) begin
                     if (in_sof) begin
                        shadow[0] <= wide_c;
                        ch_cnt    <= CNT_W'(1);
                     end else begin
                        sync_err <= 1'b1;
                        state    <= ST_HUNT;
                     end
                  end else if (in_sof) begin
                     // Early SOF: abandon the partial frame and restart on this sample.
                     sync_err  <= 1'b1;
                     shadow[0] <= wide_c;
                     ch_cnt    <= CNT_W'(1);
                  end else if (ch_cnt == LAST_CH) begin
                     shadow[ch_cnt] <= wide_c;
                     for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
                        out_data[i] <= shadow[i];
                     end
                     out_data[NUM_CH-1] <= wide_c;
                     out_valid          <= 1'b1;
                     ch_cnt             <= '0;
                  end else begin
                     shadow[ch_cnt] <= wide_c;
                     ch_cnt         <= ch_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state  <= ST_HUNT;
                  ch_cnt <= '0;
               end
            endcase
         end
      end
   end

`ifdef IN_DEMUX_ERRCNT_EN
   // Saturating count of framing violations, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (sync_err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
   end
`else
   assign err_cnt = '0;
`endif

endmodule
